stopwatch: RTL and testbench

STOPWATCH -- requirements
Module: stopwatch

---
 rtl/stopwatch_pkg.sv | 63 ++++++
 rtl/seg7_decoder.sv | 26 ++
 rtl/stopwatch.sv | 115 +++++++++++
 tb/tb_stopwatch.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, types and helpers for the stopwatch: BCD digit types,
// seven-segment table, anode one-hot-low codes and default timing parameters.
package stopwatch_pkg;

  localparam int unsigned TICK_DIV_DEF     = 1000000;
  localparam int unsigned REFRESH_BITS_DEF = 18;
  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned AN_W             = 4;
  localparam int unsigned SEL_W            = 2;

  // Active-low segments, bit0 = a ... bit6 = g, indexed by BCD value.
  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [AN_W-1:0] AN_D0 = 4'b1110;
  localparam logic [AN_W-1:0] AN_D1 = 4'b1101;
  localparam logic [AN_W-1:0] AN_D2 = 4'b1011;
  localparam logic [AN_W-1:0] AN_D3 = 4'b0111;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [SEL_W-1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_sel_e;

  // Elapsed time: d3 = tens of seconds ... d0 = hundredths.
  typedef struct packed {
    logic [DIGIT_W-1:0] d3;
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } bcd_time_t;

  typedef struct packed {
    logic               carry;
    logic [DIGIT_W-1:0] digit;
  } bcd_step_t;

  // One BCD digit stage: add the incoming carry, wrap 9 -> 0 with carry out.
  function automatic bcd_step_t bcd_digit_inc(input logic [DIGIT_W-1:0] d,
                                              input logic               cin);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (cin) begin
      if (d >= BCD_MAX) begin
        r.carry = 1'b1;
        r.digit = '0;
      end else begin
        r.digit = d + DIGIT_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decode; non-BCD codes blank the digit.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_bcd,
  output logic [SEG_W-1:0]   o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg_c = SEG_TABLE[0];
      4'd1:    o_seg_c = SEG_TABLE[1];
      4'd2:    o_seg_c = SEG_TABLE[2];
      4'd3:    o_seg_c = SEG_TABLE[3];
      4'd4:    o_seg_c = SEG_TABLE[4];
      4'd5:    o_seg_c = SEG_TABLE[5];
      4'd6:    o_seg_c = SEG_TABLE[6];
      4'd7:    o_seg_c = SEG_TABLE[7];
      4'd8:    o_seg_c = SEG_TABLE[8];
      4'd9:    o_seg_c = SEG_TABLE[9];
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch.sv
// 00.00-99.99 s stopwatch: prescaler, four-digit BCD counter with hold, and a
// free-running refresh counter multiplexing one registered digit at a time.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned REFRESH_BITS = REFRESH_BITS_DEF
) (
  input  logic             clk,
  input  logic             button_reset,
  input  logic             hold_count_switch,
  output logic [AN_W-1:0]  anode_signals,
  output logic [SEG_W-1:0] display_out
);

  localparam int unsigned        PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]      r_presc;
  logic [REFRESH_BITS-1:0] r_refresh;
  bcd_time_t               r_time;

  logic                    w_tick;
  bcd_time_t               w_time_nxt;
  bcd_step_t               w_s0;
  bcd_step_t               w_s1;
  bcd_step_t               w_s2;
  bcd_step_t               w_s3;
  digit_sel_e              w_sel;
  logic [DIGIT_W-1:0]      w_digit;
  logic [AN_W-1:0]         w_anode;
  logic [SEG_W-1:0]        w_seg;

  // Hold freezes both the prescaler and the digits, so no tick can fire.
  assign w_tick = !hold_count_switch && (r_presc == PRESC_TERM);

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      r_presc <= '0;
    end else if (!hold_count_switch) begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // Ripple the carry through all four digits in a single cycle.
  always_comb begin
    w_s0       = bcd_digit_inc(r_time.d0, w_tick);
    w_s1       = bcd_digit_inc(r_time.d1, w_s0.carry);
    w_s2       = bcd_digit_inc(r_time.d2, w_s1.carry);
    w_s3       = bcd_digit_inc(r_time.d3, w_s2.carry);
    w_time_nxt = '{d3: w_s3.digit, d2: w_s2.digit, d1: w_s1.digit, d0: w_s0.digit};
  end

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      r_time <= '0;
    end else begin
      r_time <= w_time_nxt;
    end
  end

  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + REFRESH_BITS'(1);
    end
  end

  assign w_sel = digit_sel_e'(r_refresh[REFRESH_BITS-1 -: SEL_W]);

  always_comb begin
    w_digit = r_time.d0;
    w_anode = AN_D0;
    case (w_sel)
      DIG_0: begin
        w_digit = r_time.d0;
        w_anode = AN_D0;
      end
      DIG_1: begin
        w_digit = r_time.d1;
        w_anode = AN_D1;
      end
      DIG_2: begin
        w_digit = r_time.d2;
        w_anode = AN_D2;
      end
      DIG_3: begin
        w_digit = r_time.d3;
        w_anode = AN_D3;
      end
      default: begin
        w_digit = r_time.d0;
        w_anode = AN_D0;
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .i_bcd   (w_digit),
    .o_seg_c (w_seg)
  );

  // Anode and segments share one register stage so they switch together.
  always_ff @(posedge clk or negedge button_reset) begin
    if (!button_reset) begin
      anode_signals <= AN_D0;
      display_out   <= SEG_TABLE[0];
    end else begin
      anode_signals <= w_anode;
      display_out   <= w_seg;
    end
  end

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch with TICK_DIV=4, REFRESH_BITS=4; a small
// decimal reference model predicts digits, anodes and segments each cycle.
module tb_stopwatch;

  logic       clk = 1'b0;
  logic       button_reset;
  logic       hold_count_switch;
  logic [3:0] anode_signals;
  logic [6:0] display_out;

  int total = 0;
  int bad   = 0;

  int m_presc;
  int m_ticks;
  int m_ref;

  logic [6:0] seg_ref [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  stopwatch #(
    .TICK_DIV     (4),
    .REFRESH_BITS (4)
  ) dut (
    .clk               (clk),
    .button_reset      (button_reset),
    .hold_count_switch (hold_count_switch),
    .anode_signals     (anode_signals),
    .display_out       (display_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dig(input int t, input int k);
    int v;
    v = t;
    for (int i = 0; i < k; i++) v = v / 10;
    return 4'(v % 10);
  endfunction

  function automatic logic [15:0] bcd16(input int t);
    return {dig(t, 3), dig(t, 2), dig(t, 1), dig(t, 0)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_ticks = 0;
    m_ref   = 0;
  endtask

  // One clock: predict registered outputs from pre-edge model state, advance model.
  task automatic step(input logic hold, input bit full);
    int         sel;
    logic [3:0] ea;
    logic [6:0] es;
    sel = m_ref / 4;
    ea  = ~(4'b0001 << sel);
    es  = seg_ref[dig(m_ticks, sel)];
    hold_count_switch = hold;
    if (!hold) begin
      if (m_presc == 3) begin
        m_presc = 0;
        m_ticks = (m_ticks + 1) % 10000;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    m_ref = (m_ref + 1) % 16;
    @(posedge clk);
    #1;
    if (full) begin
      chk("anode", 16'(anode_signals), 16'(ea));
      chk("segments", 16'(display_out), 16'(es));
      chk("digits", dut.r_time, bcd16(m_ticks));
    end
  endtask

  initial begin
    button_reset      = 1'b0;
    hold_count_switch = 1'b0;
    model_reset();

    // Reset held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_anode", 16'(anode_signals), 16'h000E);
    chk("rst_segments", 16'(display_out), 16'h0040);
    chk("rst_digits", dut.r_time, 16'h0000);
    button_reset = 1'b1;

    // 40 cycles -> 10 ticks -> 00.10.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("run40_digits", dut.r_time, 16'h0010);

    // Run up to 99.99 and across the wrap.
    for (int i = 40; i < 39990; i++) step(1'b0, 1'b0);
    for (int i = 39990; i < 39996; i++) step(1'b0, 1'b1);
    chk("at_9999", dut.r_time, 16'h9999);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("wrap_0000", dut.r_time, 16'h0000);

    // Count to 00.05, hold 100 cycles, release to 00.06.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("at_0005", dut.r_time, 16'h0005);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    chk("hold_0005", dut.r_time, 16'h0005);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("resume_pre", dut.r_time, 16'h0005);
    step(1'b0, 1'b1);
    chk("resume_0006", dut.r_time, 16'h0006);

    // Asynchronous reset between edges mid-count.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    #3;
    button_reset = 1'b0;
    #1;
    chk("async_anode", 16'(anode_signals), 16'h000E);
    chk("async_segments", 16'(display_out), 16'h0040);
    chk("async_digits", dut.r_time, 16'h0000);
    @(posedge clk);
    #1;
    chk("async_hold_digits", dut.r_time, 16'h0000);
    button_reset = 1'b1;
    model_reset();

    // Count to 12.34, then hold and sweep the refresh period.
    for (int i = 0; i < 4930; i++) step(1'b0, 1'b0);
    for (int i = 4930; i < 4936; i++) step(1'b0, 1'b1);
    chk("at_1234", dut.r_time, 16'h1234);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    chk("hold_1234", dut.r_time, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
